// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle for imm_gen_pipe: input beat (instr/select/tag) and registered output beat.
// IMM_GEN_RVC_EN adds the in_rvc beat qualifier.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [2:0]       in_imm_sel;
   logic [TAG_W-1:0] in_tag;
`ifdef IMM_GEN_RVC_EN
   logic             in_rvc;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic             out_err;
   logic [TAG_W-1:0] out_tag;

`ifdef IMM_GEN_RVC_EN
   modport master (
      output in_valid, in_instr, in_imm_sel, in_tag, in_rvc, out_ready,
      input  in_ready, out_valid, out_imm, out_err, out_tag
   );
   modport slave (
      input  in_valid, in_instr, in_imm_sel, in_tag, in_rvc, out_ready,
      output in_ready, out_valid, out_imm, out_err, out_tag
   );
`else
   modport master (
      output in_valid, in_instr, in_imm_sel, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_err, out_tag
   );
   modport slave (
      input  in_valid, in_instr, in_imm_sel, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_err, out_tag
   );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a registered, skid-buffered valid/ready output.
// Optional compressed-instruction decoding is enabled by defining IMM_GEN_RVC_EN.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input logic          clk,
   input logic          rst,
   imm_gen_pipe_if.slave bus
);
   typedef enum logic [2:0] {
      SEL_I   = 3'b000,
      SEL_S   = 3'b001,
      SEL_B   = 3'b010,
      SEL_J   = 3'b011,
      SEL_U   = 3'b100,
      SEL_Z   = 3'b101,
      SEL_SH  = 3'b110,
      SEL_BAD = 3'b111
   } sel_e;

   logic [31:0]      instr;
   sel_e             sel;
   logic [XLEN-1:0]  beat_imm;
   logic             beat_err;
   logic             accept;
   logic             unused_bits;

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q,   out_imm_d;
   logic             out_err_q,   out_err_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;
   logic             skd_valid_q, skd_valid_d;
   logic [XLEN-1:0]  skd_imm_q,   skd_imm_d;
   logic             skd_err_q,   skd_err_d;
   logic [TAG_W-1:0] skd_tag_q,   skd_tag_d;
   logic             in_ready_q,  in_ready_d;

   assign instr       = bus.in_instr;
   assign sel         = sel_e'(bus.in_imm_sel);
   assign unused_bits = ^instr[6:0];

`ifdef IMM_GEN_RVC_EN
   typedef enum logic [2:0] {
      C_CI   = 3'b000,
      C_CJ   = 3'b001,
      C_CB   = 3'b010,
      C_CIW  = 3'b011,
      C_CL   = 3'b100,
      C_LUI  = 3'b101
   } rvc_sel_e;
   rvc_sel_e csel;
   assign csel = rvc_sel_e'(bus.in_imm_sel);
`endif

   always_comb begin
      beat_imm = '0;
      beat_err = 1'b0;
`ifdef IMM_GEN_RVC_EN
      if (bus.in_rvc) begin
         case (csel)
            C_CI:    beat_imm = XLEN'($signed({instr[12], instr[6:2]}));
            C_CJ:    beat_imm = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                               instr[2], instr[11], instr[5:3], 1'b0}));
            C_CB:    beat_imm = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10],
                                               instr[4:3], 1'b0}));
            C_CIW:   beat_imm = XLEN'({instr[10:7], instr[12:11], instr[5], instr[6], 2'b00});
            C_CL:    beat_imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
            C_LUI:   beat_imm = XLEN'($signed({instr[12], instr[6:2], 12'b0}));
            default: beat_err = 1'b1;
         endcase
      end else
`endif
      begin
         case (sel)
            SEL_I:   beat_imm = XLEN'($signed(instr[31:20]));
            SEL_S:   beat_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            SEL_B:   beat_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            SEL_J:   beat_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            SEL_U:   beat_imm = XLEN'($signed({instr[31:12], 12'b0}));
            SEL_Z:   beat_imm = XLEN'(instr[19:15]);
            SEL_SH:  beat_imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            default: beat_err = 1'b1;
         endcase
      end
   end

   // SKD always has priority into OUT so beat order is preserved across a stall.
   always_comb begin
      out_valid_d = out_valid_q;
      out_imm_d   = out_imm_q;
      out_err_d   = out_err_q;
      out_tag_d   = out_tag_q;
      skd_valid_d = skd_valid_q;
      skd_imm_d   = skd_imm_q;
      skd_err_d   = skd_err_q;
      skd_tag_d   = skd_tag_q;
      accept      = bus.in_valid && in_ready_q;

      if (!out_valid_q || bus.out_ready) begin
         if (skd_valid_q) begin
            out_valid_d = 1'b1;
            out_imm_d   = skd_imm_q;
            out_err_d   = skd_err_q;
            out_tag_d   = skd_tag_q;
            skd_valid_d = accept;
            if (accept) begin
               skd_imm_d = beat_imm;
               skd_err_d = beat_err;
               skd_tag_d = bus.in_tag;
            end
         end else begin
            out_valid_d = accept;
            if (accept) begin
               out_imm_d = beat_imm;
               out_err_d = beat_err;
               out_tag_d = bus.in_tag;
            end
         end
      end else if (accept) begin
         skd_valid_d = 1'b1;
         skd_imm_d   = beat_imm;
         skd_err_d   = beat_err;
         skd_tag_d   = bus.in_tag;
      end

      in_ready_d = !skd_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_imm_q   <= '0;
         out_err_q   <= 1'b0;
         out_tag_q   <= '0;
         skd_valid_q <= 1'b0;
         skd_imm_q   <= '0;
         skd_err_q   <= 1'b0;
         skd_tag_q   <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         out_valid_q <= out_valid_d;
         out_imm_q   <= out_imm_d;
         out_err_q   <= out_err_d;
         out_tag_q   <= out_tag_d;
         skd_valid_q <= skd_valid_d;
         skd_imm_q   <= skd_imm_d;
         skd_err_q   <= skd_err_d;
         skd_tag_q   <= skd_tag_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_imm   = out_imm_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against a queue-based occupancy model and an arithmetic immediate reference.
module tb_imm_gen_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

   assign b64.in_valid   = b32.in_valid;
   assign b64.in_instr   = b32.in_instr;
   assign b64.in_imm_sel = b32.in_imm_sel;
   assign b64.in_tag     = b32.in_tag;
   assign b64.out_ready  = b32.out_ready;
`ifdef IMM_GEN_RVC_EN
   assign b64.in_rvc     = b32.in_rvc;
`endif

   imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
   imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

   typedef struct {
      logic [63:0] e64;
      logic [31:0] e32;
      logic        err;
      logic [7:0]  tag;
   } beat_t;

   int unsigned checks = 0;
   int unsigned errors = 0;
   beat_t       q[$];
   logic [7:0]  seen[$];
   bit          armed = 1'b0;
   bit          after_rst = 1'b0;
   bit          last_acc = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] fld(input logic [31:0] ins, input int hi, input int lo);
      logic [63:0] v;
      v = {32'b0, ins} >> lo;
      return v & ((64'd1 << (hi - lo + 1)) - 64'd1);
   endfunction

   function automatic logic [63:0] sx(input logic [63:0] v, input int w);
      if (((v >> (w - 1)) & 64'd1) != 64'd0) return v - (64'd1 << w);
      return v;
   endfunction

   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                           input bit rvc, input bit x64, output logic err);
      err = 1'b0;
      if (rvc) begin
         case (sel)
            3'd0: return sx((fld(ins,12,12) << 5) | fld(ins,6,2), 6);
            3'd1: return sx((fld(ins,12,12) << 11) | (fld(ins,8,8) << 10) | (fld(ins,10,9) << 8) |
                            (fld(ins,6,6) << 7) | (fld(ins,7,7) << 6) | (fld(ins,2,2) << 5) |
                            (fld(ins,11,11) << 4) | (fld(ins,5,3) << 1), 12);
            3'd2: return sx((fld(ins,12,12) << 8) | (fld(ins,6,5) << 6) | (fld(ins,2,2) << 5) |
                            (fld(ins,11,10) << 3) | (fld(ins,4,3) << 1), 9);
            3'd3: return (fld(ins,10,7) << 6) | (fld(ins,12,11) << 4) | (fld(ins,5,5) << 3) |
                         (fld(ins,6,6) << 2);
            3'd4: return (fld(ins,5,5) << 6) | (fld(ins,12,10) << 3) | (fld(ins,6,6) << 2);
            3'd5: return sx((fld(ins,12,12) << 17) | (fld(ins,6,2) << 12), 18);
            default: begin err = 1'b1; return 64'd0; end
         endcase
      end
      case (sel)
         3'd0: return sx(fld(ins,31,20), 12);
         3'd1: return sx((fld(ins,31,25) << 5) | fld(ins,11,7), 12);
         3'd2: return sx((fld(ins,31,31) << 12) | (fld(ins,7,7) << 11) | (fld(ins,30,25) << 5) |
                         (fld(ins,11,8) << 1), 13);
         3'd3: return sx((fld(ins,31,31) << 20) | (fld(ins,19,12) << 12) | (fld(ins,20,20) << 11) |
                         (fld(ins,30,21) << 1), 21);
         3'd4: return sx(fld(ins,31,12) << 12, 32);
         3'd5: return fld(ins,19,15);
         3'd6: return x64 ? fld(ins,25,20) : fld(ins,24,20);
         default: begin err = 1'b1; return 64'd0; end
      endcase
   endfunction

   // One cycle: check state produced by the previous edge, drive inputs, advance the model.
   task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [7:0] tag, input bit ordy, input bit r, input bit rvc);
      beat_t       b;
      logic        e;
      logic [63:0] r32;
      @(negedge clk);
      if (armed) begin
         chk("in_ready32", 64'(b32.in_ready), 64'(q.size() < 2));
         chk("in_ready64", 64'(b64.in_ready), 64'(q.size() < 2));
         chk("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
         chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
         if (q.size() > 0) begin
            chk("imm32", 64'(b32.out_imm), 64'(q[0].e32));
            chk("imm64", b64.out_imm, q[0].e64);
            chk("err32", 64'(b32.out_err), 64'(q[0].err));
            chk("err64", 64'(b64.out_err), 64'(q[0].err));
            chk("tag32", 64'(b32.out_tag), 64'(q[0].tag));
            chk("tag64", 64'(b64.out_tag), 64'(q[0].tag));
         end
         if (after_rst) begin
            chk("rst_imm", b64.out_imm | 64'(b32.out_imm), 64'd0);
            chk("rst_err", 64'(b32.out_err | b64.out_err), 64'd0);
            chk("rst_tag", 64'(b32.out_tag | b64.out_tag), 64'd0);
            after_rst = 1'b0;
         end
      end
      if (armed && !r && b32.out_valid && ordy) seen.push_back(b32.out_tag);
      rst            = r;
      b32.in_valid   = v;
      b32.in_instr   = ins;
      b32.in_imm_sel = sel;
      b32.in_tag     = tag;
      b32.out_ready  = ordy;
`ifdef IMM_GEN_RVC_EN
      b32.in_rvc     = rvc;
`endif
      if (r) begin
         q.delete();
         armed     = 1'b1;
         after_rst = 1'b1;
         last_acc  = 1'b0;
      end else begin
         last_acc = v && (q.size() < 2);
         if (q.size() > 0 && ordy) void'(q.pop_front());
         if (last_acc) begin
            b.e64 = ref_imm(ins, sel, rvc, 1'b1, e);
            b.err = e;
            r32   = ref_imm(ins, sel, rvc, 1'b0, e);
            b.e32 = r32[31:0];
            b.tag = tag;
            q.push_back(b);
         end
      end
   endtask

   task automatic send_chk(input string t, input logic [31:0] ins, input logic [2:0] sel,
                           input bit rvc, input logic [63:0] exp, input bit x64);
      step(1'b1, ins, sel, 8'h5A, 1'b1, 1'b0, rvc);
      @(posedge clk);
      #1;
      if (x64) chk(t, b64.out_imm, exp);
      else     chk(t, 64'(b32.out_imm), exp);
   endtask

   initial begin
      bit          accepted;
      bit          rvc;
      b32.in_valid   = 1'b0;
      b32.in_instr   = '0;
      b32.in_imm_sel = '0;
      b32.in_tag     = '0;
      b32.out_ready  = 1'b0;
`ifdef IMM_GEN_RVC_EN
      b32.in_rvc     = 1'b0;
`endif
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0, 0);

      send_chk("dir_I", 32'hFFF00093, 3'b000, 0, 64'h0000_0000_FFFF_FFFF, 0);
      chk("dir_I_tag", 64'(b32.out_tag), 64'h5A);
      chk("dir_I_err", 64'(b32.out_err), 64'd0);
      send_chk("dir_B", 32'hFE000EE3, 3'b010, 0, 64'h0000_0000_FFFF_FFFC, 0);
      send_chk("dir_J", 32'h0080006F, 3'b011, 0, 64'h0000_0000_0000_0008, 0);
      send_chk("dir_U64", 32'h800000B7, 3'b100, 0, 64'hFFFF_FFFF_8000_0000, 1);
      send_chk("dir_SH64", 32'h03F0D093, 3'b110, 0, 64'h0000_0000_0000_003F, 1);
      send_chk("dir_bad_imm", 32'hFFFFFFFF, 3'b111, 0, 64'd0, 0);
      chk("dir_bad_err", 64'(b32.out_err), 64'd1);
`ifdef IMM_GEN_RVC_EN
      send_chk("dir_CJ", 32'h0000BFFD, 3'b001, 1, 64'h0000_0000_FFFF_FFFE, 0);
      send_chk("dir_CIW", 32'h00001FE0, 3'b011, 1, 64'h0000_0000_0000_03FC, 0);
`endif
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);

      // Backpressure: A, B fill OUT/SKD, C must wait for the drain.
      seen.delete();
      step(1, 32'h00100093, 3'b000, 8'hA1, 0, 0, 0);
      step(1, 32'h00200093, 3'b000, 8'hB2, 0, 0, 0);
      step(1, 32'h00300093, 3'b000, 8'hC3, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("bp_in_ready", 64'(b32.in_ready), 64'd0);
      chk("bp_hold_A", 64'(b32.out_tag), 64'hA1);
      accepted = 1'b0;
      for (int i = 0; i < 8 && !accepted; i++) begin
         step(1, 32'h00300093, 3'b000, 8'hC3, 1, 0, 0);
         accepted = last_acc;
      end
      chk("bp_C_accepted", 64'(accepted), 64'd1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
      chk("bp_count", 64'(seen.size()), 64'd3);
      chk("bp_order0", 64'(seen[0]), 64'hA1);
      chk("bp_order1", 64'(seen[1]), 64'hB2);
      chk("bp_order2", 64'(seen[2]), 64'hC3);

      // Reset with both entries full.
      step(1, 32'h12345013, 3'b000, 8'hD4, 0, 0, 0);
      step(1, 32'h12345013, 3'b001, 8'hE5, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
      chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
      step(0, 0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 800; i++) begin
         rvc = 1'b0;
`ifdef IMM_GEN_RVC_EN
         rvc = 1'($urandom_range(0, 1));
`endif
         step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 99) == 0), rvc);
      end
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
